// File: rtl/block_memory_pkg.sv
// rtl/block_memory_pkg.sv - shared block size, FSM state type and default latency for block_memory
package block_memory_pkg;

  localparam int BLOCK_BYTES     = 16;
  localparam int BLOCK_BITS      = 128;
  localparam int DEFAULT_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/block_memory.sv
// rtl/block_memory.sv - fixed-latency 16-byte block memory; WRITABLE=0 gives the preloaded instruction ROM
module block_memory
  import block_memory_pkg::*;
#(
  parameter int ADDR_W       = 28,
  parameter int DEPTH_BLOCKS = 64,
  parameter int LATENCY      = DEFAULT_LATENCY,
  parameter bit WRITABLE     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [BLOCK_BITS-1:0] WRITEDATA,
  output logic [BLOCK_BITS-1:0] READDATA,
  output logic                  BUSYWAIT
);

  localparam int NUM_BYTES  = DEPTH_BLOCKS * BLOCK_BYTES;
  localparam int IDX_W      = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam int BYTE_IDX_W = $clog2(NUM_BYTES);
  localparam int CNT_W      = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  logic [7:0] MEM_ARRAY [NUM_BYTES];

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  req;
  logic                  access;
  logic                  do_write;
  logic [IDX_W-1:0]      blk;
  logic [BLOCK_BITS-1:0] rd_block;

  function automatic logic [BYTE_IDX_W-1:0] byte_idx(input logic [IDX_W-1:0] b, input int k);
    return BYTE_IDX_W'(int'(b) * BLOCK_BYTES + k);
  endfunction

  assign req      = READ | WRITE;
  assign blk      = IDX_W'(ADDRESS % ADDR_W'(DEPTH_BLOCKS));
  assign access   = (state == BUSY) && (cnt == CNT_LAST);
  // The ROM never honours WRITE, so a READ+WRITE request there falls through to a read.
  assign do_write = WRITABLE && WRITE;
  // Held low during reset so an aborted request does not keep the requester stalled.
  assign BUSYWAIT = RESET && (((state == IDLE) && req) || (state == BUSY));

  always_comb begin
    rd_block = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      rd_block[8*k +: 8] = MEM_ARRAY[byte_idx(blk, k)];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      READDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (access) begin
            state <= DONE;
            if (!do_write) READDATA <= rd_block;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; the ROM variant is only ever filled from outside by a hierarchical preload.
  if (WRITABLE) begin : g_write
    always_ff @(posedge CLK) begin
      if (RESET && access && do_write) begin
        for (int k = 0; k < BLOCK_BYTES; k++) begin
          MEM_ARRAY[byte_idx(blk, k)] <= WRITEDATA[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_block_memory.sv
// tb/tb_block_memory.sv - directed self-checking bench for block_memory (ROM and data instances)
module tb_block_memory;
  import block_memory_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         rom_read, rom_write, ram_read, ram_write;
  logic [27:0]  rom_addr, ram_addr;
  logic [127:0] rom_wdata, ram_wdata;
  logic [127:0] rom_rdata, ram_rdata;
  logic         rom_busy, ram_busy;

  int checks   = 0;
  int failures = 0;

  block_memory #(.ADDR_W(28), .DEPTH_BLOCKS(64), .LATENCY(5), .WRITABLE(1'b0)) rom (
    .CLK(clk), .RESET(rst_n), .READ(rom_read), .WRITE(rom_write), .ADDRESS(rom_addr),
    .WRITEDATA(rom_wdata), .READDATA(rom_rdata), .BUSYWAIT(rom_busy)
  );

  block_memory #(.ADDR_W(28), .DEPTH_BLOCKS(64), .LATENCY(5), .WRITABLE(1'b1)) ram (
    .CLK(clk), .RESET(rst_n), .READ(ram_read), .WRITE(ram_write), .ADDRESS(ram_addr),
    .WRITEDATA(ram_wdata), .READDATA(ram_rdata), .BUSYWAIT(ram_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Starts at a falling edge; checks BUSYWAIT over the whole access and returns READDATA in DONE.
  task automatic access(input bit sel_rom, input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] wdata, input bit hold, output logic [127:0] rdata);
    if (sel_rom) begin
      rom_read = rd; rom_write = wr; rom_addr = addr; rom_wdata = wdata;
    end else begin
      ram_read = rd; ram_write = wr; ram_addr = addr; ram_wdata = wdata;
    end
    #1;
    check("busy_request", 128'(sel_rom ? rom_busy : ram_busy), 128'(1));
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("busy_edge%0d", e), 128'(sel_rom ? rom_busy : ram_busy), 128'(1));
    end
    @(posedge clk); @(negedge clk);
    check("busy_done", 128'(sel_rom ? rom_busy : ram_busy), 128'(0));
    rdata = sel_rom ? rom_rdata : ram_rdata;
    if (!hold) begin
      if (sel_rom) begin rom_read = 1'b0; rom_write = 1'b0; end
      else begin ram_read = 1'b0; ram_write = 1'b0; end
    end
    @(posedge clk); @(negedge clk);
  endtask

  logic [127:0] rd;
  logic [127:0] rom_blk0;
  localparam logic [127:0] BLK1   = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] BLK0   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] PAT3   = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam logic [127:0] PAT67  = 128'hCAFEF00D_13579BDF_2468ACE0_0F1E2D3C;
  localparam logic [127:0] PAT5   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  initial begin
    rst_n = 1'b0;
    rom_read = 0; rom_write = 0; rom_addr = '0; rom_wdata = '0;
    ram_read = 0; ram_write = 0; ram_addr = '0; ram_wdata = '0;
    for (int i = 0; i < 1024; i++) rom.MEM_ARRAY[i] = 8'(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_rdata", ram_rdata, 128'h0);
    check("rst_rom_rdata", rom_rdata, 128'h0);
    check("rst_ram_busy", 128'(ram_busy), 128'(0));
    check("rst_ram_state", 128'(ram.state), 128'(IDLE));
    check("rst_ram_cnt", 128'(ram.cnt), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b1, 1'b1, 1'b0, 28'd1, '0, 1'b0, rd);
    check("rom_read_blk1", rd, BLK1);
    check("rom_rdata_hold", rom_rdata, BLK1);

    access(1'b0, 1'b0, 1'b1, 28'd3, PAT3, 1'b0, rd);
    access(1'b0, 1'b1, 1'b0, 28'd3, '0, 1'b0, rd);
    check("ram_readback3", rd, PAT3);

    access(1'b0, 1'b0, 1'b1, 28'd67, PAT67, 1'b0, rd);
    check("ram_write_keeps_rdata", rd, PAT3);
    access(1'b0, 1'b1, 1'b0, 28'd3, '0, 1'b0, rd);
    check("ram_wrap_67_to_3", rd, PAT67);

    access(1'b0, 1'b0, 1'b1, 28'd5, PAT5, 1'b0, rd);
    ram_write = 1'b1; ram_addr = 28'd5; ram_wdata = {128{1'b1}};
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("reset_mid_busy", 128'(ram_busy), 128'(0));
    check("reset_mid_rdata", ram_rdata, 128'h0);
    @(negedge clk);
    ram_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b1, 1'b0, 28'd5, '0, 1'b0, rd);
    check("reset_discards_write", rd, PAT5);

    access(1'b1, 1'b1, 1'b1, 28'd0, {128{1'b1}}, 1'b0, rd);
    check("rom_rw_as_read", rd, BLK0);
    for (int k = 0; k < 16; k++) rom_blk0[8*k +: 8] = rom.MEM_ARRAY[k];
    check("rom_array_unchanged", rom_blk0, BLK0);

    access(1'b1, 1'b1, 1'b0, 28'd0, '0, 1'b1, rd);
    check("rom_hold_first", rd, BLK0);
    rom_addr = 28'd1;
    access(1'b1, 1'b1, 1'b0, 28'd1, '0, 1'b0, rd);
    check("rom_hold_restart", rd, BLK1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
